logic_unit_arbiter: RTL and testbench

- Shares one registered bitwise logic unit between two requesters.
- The unit performs AND, OR, NOT-A, NAND, NOR, XOR and XNOR.
- Each requester presents an opcode and operands. The arbiter grants one requester, latches its operands, computes the result and returns a done pulse to the winner.
- Sits between the operation-issuing control blocks and the gate datapath.

---
 rtl/logic_unit_arbiter.sv | 127 ++++++++++++
 tb/tb_logic_unit_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of a registered bitwise logic unit (IDLE->GRANT->DONE).
// Define RR_ARB_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module logic_unit_arbiter_bit (
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  always_comb begin
    case (op)
      3'b000:  y = a & b;
      3'b001:  y = a | b;
      3'b010:  y = ~a;
      3'b011:  y = ~(a & b);
      3'b100:  y = ~(a | b);
      3'b101:  y = a ^ b;
      3'b110:  y = ~(a ^ b);
      default: y = 1'b0;
    endcase
  end
endmodule

module logic_unit_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t           state, state_nxt;
  logic             sel;
  logic             win;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, f_res;
  logic             gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, err_nxt, busy_nxt;
  logic [WIDTH-1:0] result_nxt;

`ifdef RR_ARB_EN
  // ptr names the requester that wins the next tie
  logic ptr;
  always_comb win = (req0 && req1) ? ptr : ~req0;
  always_ff @(posedge clk or posedge rst)
    if (rst)                                 ptr <= 1'b0;
    else if (state == IDLE && (req0 || req1)) ptr <= ~win;
`else
  always_comb win = ~req0;
`endif

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      logic_unit_arbiter_bit u_bit (.op(op_q), .a(a_q[i]), .b(b_q[i]), .y(f_res[i]));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = GRANT;
      GRANT:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0_nxt   = 1'b0;
    gnt1_nxt   = 1'b0;
    done0_nxt  = 1'b0;
    done1_nxt  = 1'b0;
    result_nxt = result;
    err_nxt    = err;
    busy_nxt   = (state_nxt != IDLE);
    case (state)
      IDLE: if (req0 || req1) begin
        gnt0_nxt = ~win;
        gnt1_nxt = win;
      end
      GRANT: begin
        result_nxt = f_res;
        err_nxt    = &op_q;
        done0_nxt  = ~sel;
        done1_nxt  = sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gnt0 <= 1'b0; gnt1 <= 1'b0; done0 <= 1'b0; done1 <= 1'b0;
      result <= '0; err <= 1'b0; busy <= 1'b0;
    end else begin
      gnt0 <= gnt0_nxt; gnt1 <= gnt1_nxt; done0 <= done0_nxt; done1 <= done1_nxt;
      result <= result_nxt; err <= err_nxt; busy <= busy_nxt;
    end

  // operands are captured at grant so requesters may move on immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel <= 1'b0; op_q <= '0; a_q <= '0; b_q <= '0;
    end else if (state == IDLE && (req0 || req1)) begin
      sel  <= win;
      op_q <= win ? op1 : op0;
      a_q  <= win ? a1 : a0;
      b_q  <= win ? b1 : b0;
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants/results, a monitor checks them.
module tb_logic_unit_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       req0 = 0, req1 = 0;
  logic [2:0] op0 = 0, op1 = 0;
  logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic       gnt0, gnt1, done0, done1, err, busy;
  logic [3:0] result;

  int checks = 0, failures = 0;

  logic_unit_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int w; logic [3:0] res; logic e; int cyc; } exp_t;
  exp_t gq[$];
  exp_t dq[$];
  int   cyc = 0;
  bit   exp_busy = 0;

  task automatic chk(input bit ok, input string name, input int act, input int expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [4:0] ref_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, ~a};
      3'd3: return {1'b0, ~(a & b)};
      3'd4: return {1'b0, ~(a | b)};
      3'd5: return {1'b0, a ^ b};
      3'd6: return {1'b0, ~(a ^ b)};
      default: return 5'b1_0000;
    endcase
  endfunction

  // reference model: one operation accepted every 3 cycles, winner chosen by the arbitration rule
  initial begin
    int cnt = 0, last = 1, w;
    logic [4:0] r;
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        cnt = 0; last = 1; gq.delete(); dq.delete();
      end else if (cnt == 0) begin
        if (req0 || req1) begin
`ifdef RR_ARB_EN
          if (req0 && req1) w = (last == 0) ? 1 : 0;
          else              w = req0 ? 0 : 1;
`else
          w = req0 ? 0 : 1;
`endif
          r = (w == 0) ? ref_op(op0, a0, b0) : ref_op(op1, a1, b1);
          e.w = w; e.res = r[3:0]; e.e = r[4]; e.cyc = cyc;
          gq.push_back(e);
          e.cyc = cyc + 1;
          dq.push_back(e);
          last = w;
          cnt  = 2;
        end
      end else cnt--;
      exp_busy = (cnt != 0);
    end
  end

  // monitor
  initial begin
    logic [3:0] h_res = 0;
    logic       h_err = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk({gnt0, gnt1, done0, done1, result, err, busy} == 0, "reset_outputs",
            {gnt0, gnt1, done0, done1, result, err, busy}, 0);
        h_res = 0; h_err = 0;
        continue;
      end
      chk(busy == exp_busy, "busy", busy, exp_busy);
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        chk(0, "missing_gnt", 0, gq[0].w); void'(gq.pop_front());
      end
      while (dq.size() > 0 && dq[0].cyc < cyc) begin
        chk(0, "missing_done", 0, dq[0].w); void'(dq.pop_front());
      end
      if (gnt0 || gnt1) begin
        chk(!(gnt0 && gnt1), "gnt_onehot", {gnt1, gnt0}, 1);
        if (gq.size() == 0) chk(0, "unexpected_gnt", {gnt1, gnt0}, 0);
        else begin
          e = gq.pop_front();
          chk(gnt1 == (e.w == 1) && gnt0 == (e.w == 0), "gnt_winner", {gnt1, gnt0}, e.w ? 2 : 1);
          chk(e.cyc == cyc, "gnt_cycle", cyc, e.cyc);
        end
      end
      if (done0 || done1) begin
        chk(!(done0 && done1), "done_onehot", {done1, done0}, 1);
        if (dq.size() == 0) chk(0, "unexpected_done", {done1, done0}, 0);
        else begin
          e = dq.pop_front();
          chk(done1 == (e.w == 1) && done0 == (e.w == 0), "done_winner", {done1, done0}, e.w ? 2 : 1);
          chk(result == e.res, "result", result, e.res);
          chk(err == e.e, "err", err, e.e);
          h_res = e.res; h_err = e.e;
        end
      end else begin
        chk(result == h_res && err == h_err, "result_held", {err, result}, {h_err, h_res});
      end
    end
  end

  task automatic wait_gnt(input int r, output bit got);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (r == 0) ? gnt0 : gnt1;
    end
    if (!got) chk(0, "gnt_timeout", 0, 1);
  endtask

  task automatic op_req(input int r, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_res, input logic exp_err);
    bit got;
    @(negedge clk);
    if (r == 0) begin req0 = 1; op0 = op; a0 = a; b0 = b; end
    else        begin req1 = 1; op1 = op; a1 = a; b1 = b; end
    wait_gnt(r, got);
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk(((r == 0) ? done0 : done1) == 1'b1, "direct_done", 0, 1);
    chk(result == exp_res, "direct_result", result, exp_res);
    chk(err == exp_err, "direct_err", err, exp_err);
    @(negedge clk);
    chk(busy == 1'b0, "direct_busy_low", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1;
    req0 = 0; req1 = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 0;
  endtask

  initial begin
    logic [3:0] tab[8];
    bit got;
    int gseq[$];
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] tab[8];
    bit got;
    int gseq[$];
    tab = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0000};
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk({gnt0, gnt1, done0, done1, result, err, busy} == 0, "post_reset", result, 0);

    op_req(0, 3'b000, 4'b1100, 4'b1010, 4'b1000, 1'b0);
    for (int k = 0; k < 8; k++)
      op_req(1, k[2:0], 4'b1100, 4'b1010, tab[k], k == 7);

    // request 1 arrives while busy; requester 0 changes operands right after grant
    @(negedge clk);
    req0 = 1; op0 = 3'b000; a0 = 4'b1100; b0 = 4'b1010;
    wait_gnt(0, got);
    req0 = 0; a0 = 4'b0000;
    req1 = 1; op1 = 3'b101; a1 = 4'b0011; b1 = 4'b0101;
    @(negedge clk);
    chk(gnt1 == 0, "no_gnt1_busy", gnt1, 0);
    chk(result == 4'b1000, "latched_operands", result, 4'b1000);
    wait_gnt(1, got);
    req1 = 0;
    repeat (3) @(negedge clk);

    // continuous tie
    do_reset();
    @(negedge clk);
    req0 = 1; req1 = 1; op0 = 3'b001; op1 = 3'b101;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt0) gseq.push_back(0);
      if (gnt1) gseq.push_back(1);
    end
    req0 = 0; req1 = 0;
    chk(gseq.size() == 4, "tie_grant_count", gseq.size(), 4);
    for (int i = 0; i < gseq.size(); i++) begin
`ifdef RR_ARB_EN
      chk(gseq[i] == i % 2, "tie_alternate", gseq[i], i % 2);
`else
      chk(gseq[i] == 0, "tie_fixed", gseq[i], 0);
`endif
    end
    repeat (4) @(negedge clk);

    // randomized traffic honouring the hold-until-grant handshake
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (req0 && gnt0) begin
        if ($urandom_range(1)) req0 = 0;
        else begin op0 = 3'($urandom); a0 = 4'($urandom); b0 = 4'($urandom); end
      end else if (!req0) begin
        if ($urandom_range(9) < 4) begin
          req0 = 1; op0 = 3'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
        end
      end else if ($urandom_range(19) == 0) req0 = 0;
      if (req1 && gnt1) begin
        if ($urandom_range(1)) req1 = 0;
        else begin op1 = 3'($urandom); a1 = 4'($urandom); b1 = 4'($urandom); end
      end else if (!req1) begin
        if ($urandom_range(9) < 4) begin
          req1 = 1; op1 = 3'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        end
      end else if ($urandom_range(19) == 0) req1 = 0;
    end
    req0 = 0; req1 = 0;
    repeat (5) @(negedge clk);

    // asynchronous reset while in GRANT
    req0 = 1; op0 = 3'b001; a0 = 4'b1100; b0 = 4'b1010;
    wait_gnt(0, got);
    #2 rst = 1;
    req0 = 0;
    #1;
    chk({gnt0, gnt1, done0, done1, result, err, busy} == 0, "async_reset", {gnt0, done0, result, busy}, 0);
    @(negedge clk);
    chk(done0 == 0 && done1 == 0, "no_done_after_reset", {done1, done0}, 0);
    #2 rst = 0;
    @(negedge clk);
    req0 = 1; req1 = 1;
    @(negedge clk);
    chk(gnt0 == 1 && gnt1 == 0, "tie_after_reset", {gnt1, gnt0}, 1);
    req0 = 0; req1 = 0;
    repeat (5) @(negedge clk);
    chk(gq.size() == 0 && dq.size() == 0, "drain", gq.size() + dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
